// File: rtl/rotary_quadrature_gen_pkg.sv
// Shared definitions for the rotary-shaft quadrature generator and its decoder:
// FSM state encoding, direction codes and the per-detent {A,B} level sequences.
package rotary_quadrature_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PH1,
    PH2,
    PH3,
    PH4,
    GAP
  } state_t;

  localparam logic DIR_CW  = 1'b0;  // A leads
  localparam logic DIR_CCW = 1'b1;  // B leads

  // {A,B} levels, packed PH1..PH4 from MSB to LSB.
  localparam logic [1:0] QUAD_IDLE    = 2'b00;
  localparam logic [7:0] QUAD_CW_SEQ  = 8'b10_11_01_00;
  localparam logic [7:0] QUAD_CCW_SEQ = 8'b01_11_10_00;

  // {A,B} level to present while in state s for direction dir.
  function automatic logic [1:0] quad_level(input state_t s, input logic dir);
    logic [7:0] seq;
    seq = (dir == DIR_CCW) ? QUAD_CCW_SEQ : QUAD_CW_SEQ;
    case (s)
      PH1:     quad_level = seq[7:6];
      PH2:     quad_level = seq[5:4];
      PH3:     quad_level = seq[3:2];
      PH4:     quad_level = seq[1:0];
      default: quad_level = QUAD_IDLE;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    max_int = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rotary_quadrature_gen_timer.sv
// Down-counting dwell timer shared by the phase and gap states. A load arms it
// with (hold - 1); expire pulses for one cycle on the last cycle of the hold.
module quad_dwell_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;
  logic         armed;

  // Reload on every state change, then count down to zero and disarm.
  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      armed <= 1'b0;
    end else if (load) begin
      count <= load_val;
      armed <= 1'b1;
    end else if (armed) begin
      if (count == '0) armed <= 1'b0;
      else             count <= count - 1'b1;
    end
  end

  assign expire = armed && (count == '0);

endmodule

// File: rtl/rotary_quadrature_gen.sv
// Turns queued (direction, detent count) commands into registered two-phase
// quadrature on ROT_A/ROT_B, one full 4-state cycle per detent, idling at 00.
module rotary_quadrature_gen
  import rotary_quadrature_gen_pkg::*;
#(
  parameter int PHASE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int STEP_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic              ROT_A,
  output logic              ROT_B,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_left
);

  localparam int DWELL_MAX = max_int(PHASE_CYCLES, GAP_CYCLES);
  localparam int DWELL_W   = ($clog2(DWELL_MAX) < 1) ? 1 : $clog2(DWELL_MAX);
  localparam logic [DWELL_W-1:0] PH_LOAD  = DWELL_W'(PHASE_CYCLES - 1);
  localparam logic [DWELL_W-1:0] GAP_LOAD = DWELL_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t              state, state_nxt;
  logic                dir_q, dir_nxt;
  logic                zero_done;
  logic                accept;
  logic                load, expire;
  logic [DWELL_W-1:0]  load_val;
  logic [STEP_W-1:0]   steps_nxt;
  logic                done_nxt;

  // A zero-detent command completes immediately but still blocks one cycle.
  assign cmd_ready = (state == IDLE) && !zero_done && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign dir_nxt   = accept ? cmd_dir : dir_q;

  quad_dwell_timer #(.W(DWELL_W)) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .expire   (expire)
  );

  // Next-state, dwell reload and step bookkeeping.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_val  = PH_LOAD;
    steps_nxt = steps_left;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_steps != '0) begin
            state_nxt = PH1;
            load      = 1'b1;
            steps_nxt = cmd_steps - 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      PH1: if (expire) begin state_nxt = PH2; load = 1'b1; end
      PH2: if (expire) begin state_nxt = PH3; load = 1'b1; end
      PH3: if (expire) begin state_nxt = PH4; load = 1'b1; end
      PH4, GAP: begin
        if (expire) begin
          if (state == PH4 && GAP_CYCLES != 0) begin
            state_nxt = GAP;
            load      = 1'b1;
            load_val  = GAP_LOAD;
          end else if (steps_left != '0) begin
            state_nxt = PH1;
            load      = 1'b1;
            steps_nxt = steps_left - 1'b1;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and all outputs registered, so ROT levels change glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dir_q      <= DIR_CW;
      ROT_A      <= 1'b0;
      ROT_B      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      steps_left <= '0;
      zero_done  <= 1'b0;
    end else begin
      state          <= state_nxt;
      dir_q          <= dir_nxt;
      {ROT_A, ROT_B} <= quad_level(state_nxt, dir_nxt);
      busy           <= (state_nxt != IDLE);
      done           <= done_nxt;
      steps_left     <= steps_nxt;
      zero_done      <= accept && (cmd_steps == '0);
    end
  end

endmodule

// File: tb/tb_rotary_quadrature_gen.sv
// Directed bench for rotary_quadrature_gen with PHASE_CYCLES=4, GAP_CYCLES=2.
module tb_rotary_quadrature_gen;

  localparam int P = 4;
  localparam int G = 2;
  localparam int T = 4 * P + G;  // cycles per detent

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [7:0] cmd_steps;
  logic       rot_a, rot_b;
  logic       busy, done;
  logic [7:0] steps_left;

  int checks   = 0;
  int failures = 0;

  rotary_quadrature_gen #(.PHASE_CYCLES(P), .GAP_CYCLES(G), .STEP_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .ROT_A      (rot_a),
    .ROT_B      (rot_b),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {A,B} in cycle j after accept (j=1 is the first cycle) for n detents.
  function automatic logic [1:0] exp_rot(input logic dir, input int j, input int n);
    int w;
    if (j < 1 || j > n * T) return 2'b00;
    w = (j - 1) % T;
    case (w / P)
      0:       return dir ? 2'b01 : 2'b10;
      1:       return 2'b11;
      2:       return dir ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Offer a command for exactly one rising edge, sampled ready beforehand.
  task automatic accept_cmd(input logic dir, input int n);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = 8'(n);
    check("ready_before_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_dir   = ~dir;
    cmd_steps = 8'hAA;
  endtask

  task automatic run_cmd(input string name, input logic dir, input int n);
    int total, hi_cnt;
    logic [1:0] cur, prev;
    total  = n * T;
    hi_cnt = 0;
    prev   = 2'b00;
    accept_cmd(dir, n);
    for (int j = 1; j <= total + 1; j++) begin
      @(negedge clk);
      cur = {rot_a, rot_b};
      check($sformatf("%s_rot_c%0d", name, j), cur, exp_rot(dir, j, n));
      check($sformatf("%s_onebit_c%0d", name, j), (cur ^ prev) == 2'b11, 0);
      check($sformatf("%s_busy_c%0d", name, j), busy, (j <= total));
      check($sformatf("%s_done_c%0d", name, j), done, (j == total + 1));
      check($sformatf("%s_left_c%0d", name, j), steps_left,
            (j <= total) ? (n - 1 - (j - 1) / T) : 0);
      if (cur == 2'b11 && prev != 2'b11) hi_cnt++;
      prev = cur;
    end
    check({name, "_ready_done"}, cmd_ready, (n != 0));
    check({name, "_ab11_events"}, hi_cnt, n);
    @(negedge clk);
    check({name, "_done_clear"}, done, 0);
    check({name, "_ready_after"}, cmd_ready, 1);
  endtask

  task automatic run_back_to_back();
    int hi_cnt;
    logic [1:0] cur, prev, exp;
    hi_cnt = 0;
    prev   = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_dir   = 1'b0;
    cmd_steps = 8'd2;
    @(posedge clk);
    #1;
    cmd_dir   = 1'b1;  // held with valid; must be ignored until the done cycle
    cmd_steps = 8'd1;
    for (int j = 1; j <= 2 * T + 1 + T + 1; j++) begin
      @(negedge clk);
      cur = {rot_a, rot_b};
      if (j <= 2 * T)          exp = exp_rot(1'b0, j, 2);
      else if (j == 2 * T + 1) exp = 2'b00;
      else                     exp = exp_rot(1'b1, j - (2 * T + 1), 1);
      check($sformatf("b2b_rot_c%0d", j), cur, exp);
      check($sformatf("b2b_onebit_c%0d", j), (cur ^ prev) == 2'b11, 0);
      check($sformatf("b2b_done_c%0d", j), done, (j == 2 * T + 1) || (j == 3 * T + 2));
      check($sformatf("b2b_busy_c%0d", j), busy, (j != 2 * T + 1) && (j != 3 * T + 2));
      if (cur == 2'b11 && prev != 2'b11) hi_cnt++;
      prev = cur;
      if (j == 2 * T + 1) begin
        check("b2b_ready_first_done", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
      end
    end
    check("b2b_ab11_events", hi_cnt, 3);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_steps = '0;

    // Power-on reset values.
    repeat (3) @(negedge clk);
    check("rst_rot", {rot_a, rot_b}, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_left", steps_left, 0);
    check("rst_ready_held", cmd_ready, 0);
    reset = 1'b0;
    #1;
    check("rst_ready_release", cmd_ready, 1);

    run_cmd("cw3", 1'b0, 3);
    run_cmd("ccw1", 1'b1, 1);
    run_cmd("zero", 1'b0, 0);
    run_back_to_back();

    // Asynchronous reset while holding PH2 (A=B=1).
    accept_cmd(1'b0, 2);
    repeat (6) @(negedge clk);
    check("midrst_pre_rot", {rot_a, rot_b}, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_rot", {rot_a, rot_b}, 2'b00);
    check("midrst_busy", busy, 0);
    check("midrst_left", steps_left, 0);
    check("midrst_ready", cmd_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_ready_release", cmd_ready, 1);
    @(negedge clk);
    check("midrst_rot_idle", {rot_a, rot_b}, 2'b00);
    check("midrst_busy_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
